// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter between the
// CPU instruction and data buses.
package sram_arb_pkg;

    // Requester port identifiers; also used as bit indices into request/grant vectors.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Tag registered alongside each accepted read so the response can be routed back.
    typedef struct packed {
        logic  valid;
        port_e owner;
    } resp_tag_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/sram_sp_arbiter_if.sv
// Bus bundle for the SRAM arbiter: two IOb-native requester ports, the SRAM side
// and the statistics counters.
//
// Handshake: a request transfers in the cycle where x_avalid_i and x_ready_o are
// both high; the requester holds avalid/addr/wdata/wstrb stable until then.
// Read data returns one cycle later, qualified by a single-cycle x_rvalid_o.
interface sram_sp_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 16
) ();

    logic                  i_avalid_i;
    logic [ADDR_W-1:0]     i_addr_i;
    logic [DATA_W-1:0]     i_wdata_i;
    logic [DATA_W/8-1:0]   i_wstrb_i;
    logic                  i_ready_o;
    logic [DATA_W-1:0]     i_rdata_o;
    logic                  i_rvalid_o;

    logic                  d_avalid_i;
    logic [ADDR_W-1:0]     d_addr_i;
    logic [DATA_W-1:0]     d_wdata_i;
    logic [DATA_W/8-1:0]   d_wstrb_i;
    logic                  d_ready_o;
    logic [DATA_W-1:0]     d_rdata_o;
    logic                  d_rvalid_o;

    logic                  mem_en_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W/8-1:0]   mem_we_o;
    logic [DATA_W-1:0]     mem_d_o;
    logic [DATA_W-1:0]     mem_dt_i;

    logic [CNT_W-1:0]      conflict_cnt_o;
    logic [CNT_W-1:0]      d_stall_cnt_o;

    modport slave (
        input  i_avalid_i, i_addr_i, i_wdata_i, i_wstrb_i,
        input  d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i,
        input  mem_dt_i,
        output i_ready_o, i_rdata_o, i_rvalid_o,
        output d_ready_o, d_rdata_o, d_rvalid_o,
        output mem_en_o, mem_addr_o, mem_we_o, mem_d_o,
        output conflict_cnt_o, d_stall_cnt_o
    );

    modport master (
        output i_avalid_i, i_addr_i, i_wdata_i, i_wstrb_i,
        output d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i,
        output mem_dt_i,
        input  i_ready_o, i_rdata_o, i_rvalid_o,
        input  d_ready_o, d_rdata_o, d_rvalid_o,
        input  mem_en_o, mem_addr_o, mem_we_o, mem_d_o,
        input  conflict_cnt_o, d_stall_cnt_o
    );

endinterface

// File: rtl/sram_arb_rr.sv
// Two-input round-robin grant: a lone requester always wins, and on a conflict
// the port that lost the previous conflict wins. Grant is one-hot or zero.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output port_e      last_grant
);

    port_e last_q;
    port_e last_d;
    logic  conflict;

    always_comb begin
        gnt      = '0;
        last_d   = last_q;
        conflict = req[PORT_I] & req[PORT_D];
        if (conflict) begin
            // Only conflict cycles move the pointer; lone grants leave it alone.
            if (last_q == PORT_D) begin
                gnt[PORT_I] = 1'b1;
                last_d      = PORT_I;
            end else begin
                gnt[PORT_D] = 1'b1;
                last_d      = PORT_D;
            end
        end else begin
            gnt = req;
        end
    end

    // Starts at D so the very first conflict goes to the instruction port.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port byte-enable SRAM between the instruction and data buses:
// request mux, read-response routing and saturating conflict/stall statistics.
module sram_sp_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    sram_sp_arbiter_if.slave   bus,
    output port_e              dbg_last_grant
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              any_req;
    logic              conflict;
    logic              sel_d;
    logic [STRB_W-1:0] sel_wstrb;
    logic              rd_accept;
    logic              i_ready;
    logic              d_ready;
    logic              d_stall;
    resp_tag_t         resp_q;
    resp_tag_t         resp_d;
    logic [CNT_W-1:0]  conflict_cnt_q;
    logic [CNT_W-1:0]  d_stall_cnt_q;

    // Requests are masked while reset is held so nothing is granted or driven to the SRAM.
    always_comb begin
        req         = '0;
        req[PORT_I] = arst_n_i & bus.i_avalid_i;
        req[PORT_D] = arst_n_i & bus.d_avalid_i;
    end

    sram_arb_rr u_rr (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .req        (req),
        .gnt        (gnt),
        .last_grant (dbg_last_grant)
    );

    assign any_req  = |req;
    assign conflict = req[PORT_I] & req[PORT_D];
    assign sel_d    = gnt[PORT_D];

    // An idle arbiter advertises ready on both ports so a new request transfers at once.
    assign i_ready = arst_n_i & (gnt[PORT_I] | ~any_req);
    assign d_ready = arst_n_i & (gnt[PORT_D] | ~any_req);
    assign d_stall = bus.d_avalid_i & ~d_ready;

    assign bus.i_ready_o = i_ready;
    assign bus.d_ready_o = d_ready;

    assign sel_wstrb      = sel_d ? bus.d_wstrb_i : bus.i_wstrb_i;
    assign bus.mem_en_o   = any_req;
    assign bus.mem_addr_o = sel_d ? bus.d_addr_i  : bus.i_addr_i;
    assign bus.mem_d_o    = sel_d ? bus.d_wdata_i : bus.i_wdata_i;
    assign bus.mem_we_o   = any_req ? sel_wstrb : '0;

    assign rd_accept = any_req & (sel_wstrb == '0);

    always_comb begin
        resp_d       = '0;
        resp_d.valid = rd_accept;
        resp_d.owner = sel_d ? PORT_D : PORT_I;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            resp_q <= '{valid: 1'b0, owner: PORT_I};
        end else begin
            resp_q <= resp_d;
        end
    end

    // The SRAM output register supplies the data; the tag only decides who sees it.
    assign bus.i_rvalid_o = resp_q.valid & (resp_q.owner == PORT_I);
    assign bus.d_rvalid_o = resp_q.valid & (resp_q.owner == PORT_D);
    assign bus.i_rdata_o  = bus.mem_dt_i;
    assign bus.d_rdata_o  = bus.mem_dt_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            conflict_cnt_q <= '0;
            d_stall_cnt_q  <= '0;
        end else begin
            if (conflict) begin
                conflict_cnt_q <= CNT_W'(sat_inc(32'(conflict_cnt_q), CNT_W));
            end
            if (d_stall) begin
                d_stall_cnt_q <= CNT_W'(sat_inc(32'(d_stall_cnt_q), CNT_W));
            end
        end
    end

    assign bus.conflict_cnt_o = conflict_cnt_q;
    assign bus.d_stall_cnt_o  = d_stall_cnt_q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Bench for sram_sp_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration and memory behaviour.
module tb_sram_sp_arbiter;
    import sram_arb_pkg::*;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 13;
    localparam int CNT_W       = 16;
    localparam int STRB_W      = DATA_W / 8;
    localparam int SMALL_CNT_W = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sram_sp_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W))       bus ();
    sram_sp_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SMALL_CNT_W)) sbus ();

    port_e dbg_last;
    port_e sdbg_last;

    sram_sp_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .bus            (bus),
        .dbg_last_grant (dbg_last)
    );

    sram_sp_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SMALL_CNT_W)) dut_small (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .bus            (sbus),
        .dbg_last_grant (sdbg_last)
    );

    // Behavioural single-port SRAM with one-cycle registered read.
    bit   [DATA_W-1:0] sram [0:63];
    logic [DATA_W-1:0] mem_dt;
    logic              pl_en = 1'b0;
    logic [5:0]        pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o == '0) begin
                mem_dt <= sram[bus.mem_addr_o[5:0]];
            end else begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (bus.mem_we_o[b]) sram[bus.mem_addr_o[5:0]][8*b +: 8] <= bus.mem_d_o[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_dt_i  = mem_dt;
    assign sbus.mem_dt_i = '0;

    // Reference model state.
    bit   [DATA_W-1:0] ref_mem [0:63];
    bit                m_next_i;
    bit                m_pend_v;
    port_e             m_pend_owner;
    logic [DATA_W-1:0] m_pend_data;
    int                m_conf;
    int                m_dstall;

    logic              obs_i_ready, obs_d_ready, obs_en, obs_i_rv, obs_d_rv;
    logic [DATA_W-1:0] obs_i_rdata, obs_d_rdata;
    logic [ADDR_W-1:0] obs_addr;
    int                obs_conf, obs_dstall;
    bit                exp_i_ready, exp_d_ready, exp_en, exp_i_rv, exp_d_rv;
    logic [DATA_W-1:0] exp_rdata;
    logic [ADDR_W-1:0] exp_addr;

    task automatic model_reset();
        m_next_i = 1'b1;
        m_pend_v = 1'b0;
        m_conf   = 0;
        m_dstall = 0;
    endtask

    task automatic drive_idle();
        bus.i_avalid_i = 1'b0; bus.i_addr_i = '0; bus.i_wdata_i = '0; bus.i_wstrb_i = '0;
        bus.d_avalid_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_wstrb_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();
    endtask

    task automatic preload(input logic [5:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        drive_idle();
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Drives one cycle from a negedge, samples combinational outputs, steps the
    // model across the rising edge and samples registered outputs at the next negedge.
    task automatic run_cycle(
        input bit ia, input logic [ADDR_W-1:0] iaddr, input logic [DATA_W-1:0] iwd, input logic [STRB_W-1:0] iws,
        input bit da, input logic [ADDR_W-1:0] daddr, input logic [DATA_W-1:0] dwd, input logic [STRB_W-1:0] dws);
        bit gi, gd;
        logic [5:0] a6;
        logic [STRB_W-1:0] ws;
        logic [DATA_W-1:0] wd;
        bus.i_avalid_i = ia; bus.i_addr_i = iaddr; bus.i_wdata_i = iwd; bus.i_wstrb_i = iws;
        bus.d_avalid_i = da; bus.d_addr_i = daddr; bus.d_wdata_i = dwd; bus.d_wstrb_i = dws;
        #1;
        obs_i_ready = bus.i_ready_o;
        obs_d_ready = bus.d_ready_o;
        obs_en      = bus.mem_en_o;
        obs_addr    = bus.mem_addr_o;
        gi = ia && (!da || m_next_i);
        gd = da && !gi;
        exp_i_ready = gi || !(ia || da);
        exp_d_ready = gd || !(ia || da);
        exp_en      = ia || da;
        exp_addr    = gi ? iaddr : daddr;
        @(posedge clk);
        if (ia && da) begin
            if (m_conf < CNT_MAX) m_conf++;
            m_next_i = gd;
        end
        if (da && !gd && m_dstall < CNT_MAX) m_dstall++;
        m_pend_v = 1'b0;
        if (gi || gd) begin
            a6 = gi ? iaddr[5:0] : daddr[5:0];
            ws = gi ? iws : dws;
            wd = gi ? iwd : dwd;
            if (ws == '0) begin
                m_pend_v     = 1'b1;
                m_pend_owner = gi ? PORT_I : PORT_D;
                m_pend_data  = ref_mem[a6];
            end else begin
                for (int b = 0; b < STRB_W; b++) if (ws[b]) ref_mem[a6][8*b +: 8] = wd[8*b +: 8];
            end
        end
        @(negedge clk);
        obs_i_rv    = bus.i_rvalid_o;
        obs_d_rv    = bus.d_rvalid_o;
        obs_i_rdata = bus.i_rdata_o;
        obs_d_rdata = bus.d_rdata_o;
        obs_conf    = int'(bus.conflict_cnt_o);
        obs_dstall  = int'(bus.d_stall_cnt_o);
        exp_i_rv    = m_pend_v && (m_pend_owner == PORT_I);
        exp_d_rv    = m_pend_v && (m_pend_owner == PORT_D);
        exp_rdata   = m_pend_data;
    endtask

    task automatic test_reset();
        bus.i_avalid_i = 1'b1; bus.d_avalid_i = 1'b1;
        #2;
        total++; if (bus.i_ready_o !== 1'b0) begin bad++; $display("FAIL reset_i_ready got=%b want=0", bus.i_ready_o); end
        total++; if (bus.d_ready_o !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b want=0", bus.d_ready_o); end
        total++; if (bus.mem_en_o !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b want=0", bus.mem_en_o); end
        total++; if ({bus.i_rvalid_o, bus.d_rvalid_o} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", {bus.i_rvalid_o, bus.d_rvalid_o}); end
        total++; if (bus.conflict_cnt_o !== '0) begin bad++; $display("FAIL reset_conflict_cnt got=%0d want=0", bus.conflict_cnt_o); end
        total++; if (bus.d_stall_cnt_o !== '0) begin bad++; $display("FAIL reset_d_stall_cnt got=%0d want=0", bus.d_stall_cnt_o); end
        do_reset();
    endtask

    task automatic test_single_read();
        preload(6'h10, 32'hDEADBEEF);
        run_cycle(1'b1, ADDR_W'(16), '0, '0, 1'b0, '0, '0, '0);
        total++; if (obs_i_ready !== 1'b1) begin bad++; $display("FAIL single_i_ready got=%b want=1", obs_i_ready); end
        total++; if (obs_addr !== ADDR_W'(16)) begin bad++; $display("FAIL single_mem_addr got=%h want=010", obs_addr); end
        total++; if (obs_i_rv !== 1'b1) begin bad++; $display("FAIL single_i_rvalid got=%b want=1", obs_i_rv); end
        total++; if (obs_i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_i_rdata got=%h want=deadbeef", obs_i_rdata); end
        total++; if (obs_d_rv !== 1'b0) begin bad++; $display("FAIL single_d_rvalid got=%b want=0", obs_d_rv); end
        run_cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        total++; if ({obs_i_rv, obs_d_rv} !== 2'b00) begin bad++; $display("FAIL single_rvalid_pulse got=%b want=00", {obs_i_rv, obs_d_rv}); end
        total++; if ({obs_i_ready, obs_d_ready, obs_en} !== 3'b110) begin bad++; $display("FAIL idle_ready_en got=%b want=110", {obs_i_ready, obs_d_ready, obs_en}); end
    endtask

    task automatic test_conflict();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            run_cycle(1'b1, ADDR_W'(16), '0, '0, 1'b1, ADDR_W'(32), '0, '0);
            total++; if (obs_i_ready !== (k % 2 == 0)) begin bad++; $display("FAIL conflict_i_ready k=%0d got=%b want=%b", k, obs_i_ready, (k % 2 == 0)); end
            total++; if (obs_d_ready !== (k % 2 == 1)) begin bad++; $display("FAIL conflict_d_ready k=%0d got=%b want=%b", k, obs_d_ready, (k % 2 == 1)); end
            total++; if ({obs_i_rv, obs_d_rv} !== {exp_i_rv, exp_d_rv}) begin bad++; $display("FAIL conflict_rvalid k=%0d got=%b want=%b", k, {obs_i_rv, obs_d_rv}, {exp_i_rv, exp_d_rv}); end
            total++; if (obs_i_rdata !== exp_rdata) begin bad++; $display("FAIL conflict_rdata k=%0d got=%h want=%h", k, obs_i_rdata, exp_rdata); end
        end
        total++; if (obs_conf !== 6) begin bad++; $display("FAIL conflict_cnt got=%0d want=6", obs_conf); end
        total++; if (obs_dstall !== 3) begin bad++; $display("FAIL d_stall_cnt got=%0d want=3", obs_dstall); end
    endtask

    task automatic test_write_strobe();
        run_cycle(1'b0, '0, '0, '0, 1'b1, ADDR_W'(32), 32'h12345678, 4'b0101);
        total++; if (obs_d_ready !== 1'b1) begin bad++; $display("FAIL wstrb_d_ready got=%b want=1", obs_d_ready); end
        total++; if ({obs_i_rv, obs_d_rv} !== 2'b00) begin bad++; $display("FAIL wstrb_no_rvalid got=%b want=00", {obs_i_rv, obs_d_rv}); end
        run_cycle(1'b0, '0, '0, '0, 1'b1, ADDR_W'(32), '0, '0);
        total++; if (obs_d_rv !== 1'b1) begin bad++; $display("FAIL wstrb_read_rvalid got=%b want=1", obs_d_rv); end
        total++; if (obs_d_rdata !== 32'h00340078) begin bad++; $display("FAIL wstrb_read_data got=%h want=00340078", obs_d_rdata); end
    endtask

    task automatic test_write_then_read();
        logic [DATA_W-1:0] v;
        v = $urandom;
        run_cycle(1'b1, ADDR_W'(48), v, 4'b1111, 1'b0, '0, '0, '0);
        total++; if (obs_i_ready !== 1'b1) begin bad++; $display("FAIL wr_i_ready got=%b want=1", obs_i_ready); end
        run_cycle(1'b0, '0, '0, '0, 1'b1, ADDR_W'(48), '0, '0);
        total++; if (obs_d_rv !== 1'b1 || obs_d_rdata !== v) begin bad++; $display("FAIL wr_then_rd got=%b/%h want=1/%h", obs_d_rv, obs_d_rdata, v); end
    endtask

    task automatic test_random();
        bit ip, dp;
        logic [ADDR_W-1:0] ia, da;
        logic [DATA_W-1:0] iw, dw;
        logic [STRB_W-1:0] is, ds;
        ip = 0; dp = 0; ia = '0; da = '0; iw = '0; dw = '0; is = '0; ds = '0;
        for (int c = 0; c < 300; c++) begin
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1; ia = ADDR_W'($urandom_range(0, 63)); iw = $urandom;
                is = ($urandom_range(0, 1) == 0) ? '0 : STRB_W'($urandom_range(0, 15));
            end
            if (!dp && $urandom_range(0, 3) != 0) begin
                dp = 1; da = ADDR_W'($urandom_range(0, 63)); dw = $urandom;
                ds = ($urandom_range(0, 1) == 0) ? '0 : STRB_W'($urandom_range(0, 15));
            end
            run_cycle(ip, ia, iw, is, dp, da, dw, ds);
            total++; if ({obs_i_ready, obs_d_ready} !== {exp_i_ready, exp_d_ready}) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, {obs_i_ready, obs_d_ready}, {exp_i_ready, exp_d_ready}); end
            total++; if (obs_en !== exp_en) begin bad++; $display("FAIL rand_mem_en c=%0d got=%b want=%b", c, obs_en, exp_en); end
            if (exp_en) begin
                total++; if (obs_addr !== exp_addr) begin bad++; $display("FAIL rand_mem_addr c=%0d got=%h want=%h", c, obs_addr, exp_addr); end
            end
            total++; if ({obs_i_rv, obs_d_rv} !== {exp_i_rv, exp_d_rv}) begin bad++; $display("FAIL rand_rvalid c=%0d got=%b want=%b", c, {obs_i_rv, obs_d_rv}, {exp_i_rv, exp_d_rv}); end
            if (exp_i_rv || exp_d_rv) begin
                total++; if (obs_d_rdata !== exp_rdata) begin bad++; $display("FAIL rand_rdata c=%0d got=%h want=%h", c, obs_d_rdata, exp_rdata); end
            end
            total++; if (obs_conf !== m_conf || obs_dstall !== m_dstall) begin bad++; $display("FAIL rand_counters c=%0d got=%0d/%0d want=%0d/%0d", c, obs_conf, obs_dstall, m_conf, m_dstall); end
            if (ip && exp_i_ready) ip = 0;
            if (dp && exp_d_ready) dp = 0;
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive_idle();
        bus.d_avalid_i = 1'b1; bus.d_addr_i = ADDR_W'(16);
        @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        total++; if (bus.d_rvalid_o !== 1'b0) begin bad++; $display("FAIL midrst_d_rvalid got=%b want=0", bus.d_rvalid_o); end
        total++; if ({bus.i_ready_o, bus.d_ready_o} !== 2'b00) begin bad++; $display("FAIL midrst_ready got=%b want=00", {bus.i_ready_o, bus.d_ready_o}); end
        total++; if (bus.conflict_cnt_o !== '0 || bus.d_stall_cnt_o !== '0) begin bad++; $display("FAIL midrst_counters got=%0d/%0d want=0/0", bus.conflict_cnt_o, bus.d_stall_cnt_o); end
        total++; if (bus.mem_en_o !== 1'b0) begin bad++; $display("FAIL midrst_mem_en got=%b want=0", bus.mem_en_o); end
        @(negedge clk);
        drive_idle();
        arst_n = 1'b1;
        model_reset();
        run_cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        total++; if ({obs_i_rv, obs_d_rv} !== 2'b00) begin bad++; $display("FAIL midrst_no_reissue got=%b want=00", {obs_i_rv, obs_d_rv}); end
    endtask

    task automatic test_saturate();
        int exp_c, exp_s;
        do_reset();
        sbus.i_avalid_i = 1'b1; sbus.d_avalid_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_c = (k > 7) ? 7 : k;
            exp_s = ((k + 1) / 2 > 7) ? 7 : (k + 1) / 2;
            total++; if (int'(sbus.conflict_cnt_o) !== exp_c) begin bad++; $display("FAIL sat_conflict k=%0d got=%0d want=%0d", k, sbus.conflict_cnt_o, exp_c); end
            total++; if (int'(sbus.d_stall_cnt_o) !== exp_s) begin bad++; $display("FAIL sat_d_stall k=%0d got=%0d want=%0d", k, sbus.d_stall_cnt_o, exp_s); end
        end
        sbus.i_avalid_i = 1'b0; sbus.d_avalid_i = 1'b0;
    endtask

    initial begin
        drive_idle();
        sbus.i_avalid_i = 1'b0; sbus.i_addr_i = '0; sbus.i_wdata_i = '0; sbus.i_wstrb_i = '0;
        sbus.d_avalid_i = 1'b0; sbus.d_addr_i = '0; sbus.d_wdata_i = '0; sbus.d_wstrb_i = '0;
        model_reset();
        test_reset();
        test_single_read();
        test_conflict();
        test_write_strobe();
        test_write_then_read();
        test_random();
        test_reset_mid_read();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_sp_arbiter.md
# sram_sp_arbiter

Arbiter that shares one single-port byte-enable SRAM (one access per cycle, one-cycle registered read) between the CPU instruction and data buses. It sits between the two IOb-native requester ports and the `iob_ram_sp_be` instance. It provides real `ready` backpressure, round-robin fairness on conflicts, and routing of read responses back to the requester that issued them. Saturating conflict/stall counters feed the SoC debug registers.

## Interface
- `DATA_W`, 32, data width in bits (multiple of 8)
- `ADDR_W`, 13, word address width (SRAM_ADDR_W-2)
- `CNT_W`, 16, width of the saturating statistics counters
- `clk_i` in 1: clock, all state on rising edge
- `arst_n_i` in 1: asynchronous, active-low reset
- `i_avalid_i` in 1: instruction request valid
- `i_addr_i` in ADDR_W: instruction word address
- `i_wdata_i` in DATA_W: instruction write data (boot loading)
- `i_wstrb_i` in DATA_W/8: instruction byte strobes; 0 = read
- `i_ready_o` out 1: instruction request accepted this cycle
- `i_rdata_o` out DATA_W: instruction read data
- `i_rvalid_o` out 1: instruction read data valid
- `d_avalid_i`, `d_addr_i`, `d_wdata_i`, `d_wstrb_i`, `d_ready_o`, `d_rdata_o`, `d_rvalid_o`: same as the instruction port, for the data bus
- `mem_en_o` out 1: SRAM enable
- `mem_addr_o` out ADDR_W: SRAM address
- `mem_we_o` out DATA_W/8: SRAM byte write enables
- `mem_d_o` out DATA_W: SRAM write data
- `mem_dt_i` in DATA_W: SRAM read data, valid the cycle after an enabled read
- `conflict_cnt_o` out CNT_W: cycles in which both ports requested
- `d_stall_cnt_o` out CNT_W: cycles in which `d_avalid_i` was high and `d_ready_o` was low

## Operation
- Transfer: a request completes when `x_avalid_i & x_ready_o` are high in the same cycle. The requester holds `avalid`, `addr`, `wdata` and `wstrb` stable until the transfer.
- Grant:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not granted in the most recent conflict cycle is granted.
  - `last_conflict_grant` updates only on conflict cycles.
  - Reset value is D, so the first conflict goes to I.
- The granted port gets `ready=1`; the other port gets `ready=0`. With no request, both `ready` outputs are 1, `mem_en_o=0`, and the `mem_*` outputs are don't-care.
- `mem_en_o`, `mem_addr_o`, `mem_we_o` and `mem_d_o` are a combinational mux of the granted port.
- Response tracking: on an accepted read (`wstrb==0`), register `resp_valid=1` and `resp_owner=port`. Otherwise `resp_valid=0`.
- Response outputs: `x_rvalid_o = resp_valid & (resp_owner==x)`. Both `i_rdata_o` and `d_rdata_o` carry `mem_dt_i` and are meaningful only when `x_rvalid_o` is high.
- Writes produce no `rvalid`.
- Counters saturate at 2^CNT_W-1 and never wrap. They clear only on reset.

## Timing
- Read latency: the accept in cycle N produces `rvalid` plus data in cycle N+1.
- Throughput: one access per cycle in total. Back-to-back reads from either port are allowed; each `rvalid` pulse is exactly one cycle.
- `ready` is combinational from both `avalid` inputs and `last_conflict_grant`. There is no combinational path from `mem_dt_i` to `ready`.
- Sustained conflict: grants alternate I, D, I, D…, so neither port waits more than 1 cycle.
- Reset values, all applied asynchronously:
  - `last_conflict_grant=D`
  - `resp_valid=0`, so both `rvalid` outputs are 0
  - `conflict_cnt_o=0`, `d_stall_cnt_o=0`
- While `arst_n_i` is low: both `ready` outputs are 0 and `mem_en_o=0`.
- Reset asserted mid-read: the pending `rvalid` is discarded and is not reissued after release.
- Release: the first grant is possible in the first clock edge after `arst_n_i` rises.

## Structure
- Package `sram_arb_pkg`:
  - port encoding `PORT_I=1'b0`, `PORT_D=1'b1`
  - saturating-increment function for counters
- Sub-module `sram_arb_rr`: 2-input round-robin grant logic holding the `last_conflict_grant` register. It outputs a one-hot grant.
- Top level holds the request mux, the response tag registers and the counters.

## Test plan
- I read `addr 0x10` alone (memory preloaded `0x10=0xDEADBEEF`) → `i_ready_o=1` in cycle 0; `i_rvalid_o=1`, `i_rdata_o=0xDEADBEEF` in cycle 1; `d_rvalid_o=0` throughout.
- I and D both read continuously for 6 cycles after reset → grant order I, D, I, D, I, D; `conflict_cnt_o=6`; `d_stall_cnt_o=3`.
- D write `0x20=0x12345678`, `wstrb=4'b0101`, to a word holding 0 → no `rvalid`; a following D read returns `0x00340078` one cycle after accept.
- I write then D read of the same address in consecutive cycles → D read returns the newly written value.
- Assert `arst_n_i` in the cycle after a D read is accepted → `d_rvalid_o` stays 0, both counters read 0, both `ready` outputs are 0 while reset is held.
- With CNT_W=3, force a conflict for 10 cycles → `conflict_cnt_o` saturates at 7 and holds.
